// File: rtl/norm_lzc_sched.sv
// norm_lzc_sched: two-requester normalization engine.
// A round-robin arbiter in IDLE accepts one unnormalized mantissa/exponent
// pair (adder or multiplier path), COUNT registers its leading-zero count,
// SHIFT registers the normalized (or denormal-clamped) result and DONE
// presents it until the consumer takes it.
module norm_lzc_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    input  logic [23:0] a_mant,
    input  logic [7:0]  a_exp,
    output logic        a_ready,
    input  logic        m_valid,
    input  logic [23:0] m_mant,
    input  logic [7:0]  m_exp,
    output logic        m_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_mant,
    output logic [7:0]  out_exp,
    output logic        out_src,
    output logic        out_zero,
    output logic        out_uflow,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_q;
    logic        last_grant_m_q;   // 1 = multiplier was granted last
    logic [23:0] mant_q;
    logic [7:0]  exp_q;
    logic        src_q;
    logic [4:0]  lz_q;

    logic        out_valid_q;
    logic [23:0] out_mant_q;
    logic [7:0]  out_exp_q;
    logic        out_src_q;
    logic        out_zero_q;
    logic        out_uflow_q;
    logic        busy_q;

    logic        idle;
    logic        grant_a;
    logic        grant_m;
    logic [23:0] zero_pre;
    logic [4:0]  lz_d;
    logic [23:0] res_mant_d;
    logic [7:0]  res_exp_d;
    logic        res_zero_d;
    logic        res_uflow_d;
    logic [7:0]  uf_shift;

    assign idle = (state_q == ST_IDLE);

    // Round-robin: a lone requester wins; with both pending, the one not
    // granted last time wins. Ready is only ever offered in IDLE and never
    // while reset is held.
    assign grant_m = m_valid && (!a_valid || !last_grant_m_q);
    assign grant_a = a_valid && !grant_m;
    assign a_ready = rst_n && idle && grant_a;
    assign m_ready = rst_n && idle && grant_m;

    // zero_pre[i] is set when bits [23:i] of the captured mantissa are all
    // zero; the leading-zero count is simply how many of these are set.
    genvar gi;
    generate
        for (gi = 0; gi < 24; gi++) begin : g_zero_pre
            assign zero_pre[gi] = ~|mant_q[23:gi];
        end
    endgenerate

    // Population count of the all-zero prefix flags gives 0..24.
    always_comb begin
        lz_d = 5'd0;
        for (int i = 0; i < 24; i++) begin
            lz_d = lz_d + {4'd0, zero_pre[i]};
        end
    end

    assign uf_shift = (exp_q == 8'd0) ? 8'd0 : (exp_q - 8'd1);

    // Normalized result: full shift when the exponent can absorb it,
    // otherwise shift only as far as exponent 1 allows and flag a denormal.
    always_comb begin
        res_mant_d  = 24'd0;
        res_exp_d   = 8'd0;
        res_uflow_d = 1'b0;
        res_zero_d  = (lz_q == 5'd24);
        if (!res_zero_d) begin
            if (exp_q > {3'b000, lz_q}) begin
                res_mant_d = mant_q << lz_q;
                res_exp_d  = exp_q - {3'b000, lz_q};
            end else begin
                res_mant_d  = mant_q << uf_shift;
                res_uflow_d = 1'b1;
            end
        end
    end

    // Sequencer: accept, count, shift, hold result until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            last_grant_m_q <= 1'b1;
            mant_q         <= 24'd0;
            exp_q          <= 8'd0;
            src_q          <= 1'b0;
            lz_q           <= 5'd0;
            out_valid_q    <= 1'b0;
            out_mant_q     <= 24'd0;
            out_exp_q      <= 8'd0;
            out_src_q      <= 1'b0;
            out_zero_q     <= 1'b0;
            out_uflow_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_a || grant_m) begin
                        mant_q         <= grant_m ? m_mant : a_mant;
                        exp_q          <= grant_m ? m_exp : a_exp;
                        src_q          <= grant_m;
                        last_grant_m_q <= grant_m;
                        busy_q         <= 1'b1;
                        state_q        <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    lz_q    <= lz_d;
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    out_mant_q  <= res_mant_d;
                    out_exp_q   <= res_exp_d;
                    out_zero_q  <= res_zero_d;
                    out_uflow_q <= res_uflow_d;
                    out_src_q   <= src_q;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_mant  = out_mant_q;
    assign out_exp   = out_exp_q;
    assign out_src   = out_src_q;
    assign out_zero  = out_zero_q;
    assign out_uflow = out_uflow_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_norm_lzc_sched.sv
// Self-checking bench for norm_lzc_sched: directed cases, arbitration,
// backpressure, reset mid-operation and randomized transactions against a
// behavioural normalization model.
module tb_norm_lzc_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, m_valid, out_ready;
    logic [23:0] a_mant, m_mant;
    logic [7:0]  a_exp, m_exp;
    logic        a_ready, m_ready, out_valid;
    logic [23:0] out_mant;
    logic [7:0]  out_exp;
    logic        out_src, out_zero, out_uflow, busy;

    int n_cmp = 0;
    int n_err = 0;
    bit last_m = 1'b1;   // model of arbitration history: 1 = M granted last

    norm_lzc_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_valid  (a_valid),
        .a_mant   (a_mant),
        .a_exp    (a_exp),
        .a_ready  (a_ready),
        .m_valid  (m_valid),
        .m_mant   (m_mant),
        .m_exp    (m_exp),
        .m_ready  (m_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mant (out_mant),
        .out_exp  (out_exp),
        .out_src  (out_src),
        .out_zero (out_zero),
        .out_uflow(out_uflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural normalization: count leading zeros by scanning, then
    // apply the zero / normal / denormal rules with plain arithmetic.
    function automatic void ref_norm(input logic [23:0] m, input logic [7:0] e,
                                     output logic [23:0] om, output logic [7:0] oe,
                                     output bit z, output bit u);
        int lz = 0;
        int sh;
        while (lz < 24 && m[23 - lz] == 1'b0) lz++;
        om = 24'd0; oe = 8'd0; z = 1'b0; u = 1'b0;
        if (lz == 24) begin
            z = 1'b1;
        end else if (int'(e) > lz) begin
            om = 24'(m << lz);
            oe = 8'(int'(e) - lz);
        end else begin
            sh = (e == 8'd0) ? 0 : int'(e) - 1;
            om = 24'(m << sh);
            u  = 1'b1;
        end
    endfunction

    // One full transaction from IDLE back to IDLE, with bp cycles of
    // consumer backpressure while the result is presented.
    task automatic do_txn(input bit av, input bit mv,
                          input logic [23:0] am, input logic [7:0] ae,
                          input logic [23:0] mm, input logic [7:0] me,
                          input int bp,
                          output logic [23:0] o_mant, output logic [7:0] o_exp,
                          output logic o_src, output logic o_zero, output logic o_uflow);
        logic [23:0] em;
        logic [7:0]  ee;
        bit          ez, eu, es;
        a_valid = av; a_mant = am; a_exp = ae;
        m_valid = mv; m_mant = mm; m_exp = me;
        out_ready = (bp == 0);
        #1;
        es = (av && mv) ? !last_m : mv;
        n_cmp++;
        if (a_ready !== !es || m_ready !== es) begin
            n_err++;
            $display("FAIL grant: a_ready=%b m_ready=%b required a_ready=%b m_ready=%b", a_ready, m_ready, !es, es);
        end
        tick();
        last_m  = es;
        a_valid = 1'b0;
        m_valid = 1'b0;
        if (es) ref_norm(mm, me, em, ee, ez, eu);
        else    ref_norm(am, ae, em, ee, ez, eu);
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) tick();
            n_cmp++;
            if (out_valid !== (c == 3) || busy !== 1'b1) begin
                n_err++;
                $display("FAIL latency: cycle %0d out_valid=%b busy=%b required out_valid=%b busy=1", c, out_valid, busy, (c == 3));
            end
        end
        n_cmp++;
        if ({out_mant, out_exp, out_src, out_zero, out_uflow} !== {em, ee, es, ez, eu}) begin
            n_err++;
            $display("FAIL result: mant=%h exp=%0d src=%b z=%b u=%b required mant=%h exp=%0d src=%b z=%b u=%b",
                     out_mant, out_exp, out_src, out_zero, out_uflow, em, ee, es, ez, eu);
        end
        o_mant = out_mant; o_exp = out_exp; o_src = out_src; o_zero = out_zero; o_uflow = out_uflow;
        for (int k = 0; k < bp; k++) begin
            a_valid = 1'b1; m_valid = 1'b1;
            a_mant = 24'($urandom); m_mant = 24'($urandom);
            #1;
            n_cmp++;
            if (a_ready !== 1'b0 || m_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_ready: a_ready=%b m_ready=%b required 0 0", a_ready, m_ready);
            end
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || {out_mant, out_exp, out_src, out_zero, out_uflow} !== {em, ee, es, ez, eu}) begin
                n_err++;
                $display("FAIL bp_hold: valid=%b mant=%h exp=%0d required valid=1 mant=%h exp=%0d",
                         out_valid, out_mant, out_exp, em, ee);
            end
        end
        out_ready = 1'b1; a_valid = 1'b1; m_valid = 1'b1;
        #1;
        n_cmp++;
        if (a_ready !== 1'b0 || m_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL done_hs: a_ready=%b m_ready=%b out_valid=%b required 0 0 1", a_ready, m_ready, out_valid);
        end
        tick();
        a_valid = 1'b0; m_valid = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL return_idle: busy=%b out_valid=%b required 0 0", busy, out_valid);
        end
        $display("txn src=%0d mant=%h exp=%0d bp=%0d -> out_mant=%h out_exp=%0d zero=%0d uflow=%0d",
                 es, es ? mm : am, es ? me : ae, bp, o_mant, o_exp, o_zero, o_uflow);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        last_m = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_valid = 1'b1; m_valid = 1'b1;
        tick();
        n_cmp++;
        if (a_ready !== 1'b0 || m_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: a_ready=%b m_ready=%b required 0 0", a_ready, m_ready);
        end
        n_cmp++;
        if ({busy, out_valid, out_mant, out_exp, out_src, out_zero, out_uflow} !== 37'd0) begin
            n_err++;
            $display("FAIL reset_outs: busy=%b valid=%b mant=%h exp=%0d src=%b z=%b u=%b required all 0",
                     busy, out_valid, out_mant, out_exp, out_src, out_zero, out_uflow);
        end
        a_valid = 1'b0; m_valid = 1'b0;
        rst_n = 1'b1;
        last_m = 1'b1;
        tick();
        $display("txn reset checked");
    endtask

    task automatic test_single_a();
        logic [23:0] om; logic [7:0] oe; logic os, oz, ou;
        do_txn(1'b1, 1'b0, 24'h00F000, 8'd100, 24'h0, 8'd0, 0, om, oe, os, oz, ou);
        n_cmp++;
        if ({om, oe, os, oz, ou} !== {24'hF00000, 8'd92, 3'b000}) begin
            n_err++;
            $display("FAIL single_a: mant=%h exp=%0d src=%b z=%b u=%b required F00000 92 0 0 0", om, oe, os, oz, ou);
        end
    endtask

    task automatic test_zero();
        logic [23:0] om; logic [7:0] oe; logic os, oz, ou;
        do_txn(1'b0, 1'b1, 24'h0, 8'd0, 24'h000000, 8'd50, 0, om, oe, os, oz, ou);
        n_cmp++;
        if ({om, oe, os, oz, ou} !== {24'h000000, 8'd0, 3'b110}) begin
            n_err++;
            $display("FAIL zero: mant=%h exp=%0d src=%b z=%b u=%b required 000000 0 1 1 0", om, oe, os, oz, ou);
        end
    endtask

    task automatic test_underflow();
        logic [23:0] om; logic [7:0] oe; logic os, oz, ou;
        do_txn(1'b1, 1'b0, 24'h000001, 8'd5, 24'h0, 8'd0, 0, om, oe, os, oz, ou);
        n_cmp++;
        if ({om, oe, oz, ou} !== {24'h000010, 8'd0, 2'b01}) begin
            n_err++;
            $display("FAIL underflow: mant=%h exp=%0d z=%b u=%b required 000010 0 0 1", om, oe, oz, ou);
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] om; logic [7:0] oe; logic os, oz, ou;
        do_txn(1'b1, 1'b0, 24'h123456, 8'd10, 24'h0, 8'd0, 5, om, oe, os, oz, ou);
        n_cmp++;
        if ({om, oe, oz, ou} !== {24'h91A2B0, 8'd7, 2'b00}) begin
            n_err++;
            $display("FAIL backpressure: mant=%h exp=%0d z=%b u=%b required 91A2B0 7 0 0", om, oe, oz, ou);
        end
    endtask

    // Both requesters held from reset release: grants alternate A, M, ...
    // with one accept every 4 cycles and the result 3 cycles after each.
    task automatic test_arbitration();
        logic [23:0] am_r, mm_r;
        logic [7:0]  ae_r, me_r;
        bit          az, au, mz, mu;
        bit          gm;
        int          phase;
        do_reset();
        a_mant = 24'h000F00; a_exp = 8'd40;
        m_mant = 24'h0000FF; m_exp = 8'd3;
        ref_norm(a_mant, a_exp, am_r, ae_r, az, au);
        ref_norm(m_mant, m_exp, mm_r, me_r, mz, mu);
        a_valid = 1'b1; m_valid = 1'b1; out_ready = 1'b1;
        #1;
        for (int c = 0; c < 16; c++) begin
            phase = c % 4;
            gm = ((c / 4) % 2) == 1;
            n_cmp++;
            if (a_ready !== (phase == 0 && !gm) || m_ready !== (phase == 0 && gm) || out_valid !== (phase == 3)) begin
                n_err++;
                $display("FAIL arb: cycle %0d a_ready=%b m_ready=%b out_valid=%b required %b %b %b",
                         c, a_ready, m_ready, out_valid, (phase == 0 && !gm), (phase == 0 && gm), (phase == 3));
            end
            if (phase == 3) begin
                n_cmp++;
                if (out_src !== gm || out_mant !== (gm ? mm_r : am_r) || out_exp !== (gm ? me_r : ae_r)
                    || out_uflow !== (gm ? mu : au)) begin
                    n_err++;
                    $display("FAIL arb_result: cycle %0d src=%b mant=%h exp=%0d required src=%b mant=%h exp=%0d",
                             c, out_src, out_mant, out_exp, gm, gm ? mm_r : am_r, gm ? me_r : ae_r);
                end
                $display("txn arb grant=%0d mant=%h exp=%0d", out_src, out_mant, out_exp);
            end
            tick();
        end
        a_valid = 1'b0; m_valid = 1'b0;
        last_m = 1'b1;
        tick();
    endtask

    task automatic test_reset_midop();
        a_valid = 1'b1; a_mant = 24'h00ABCD; a_exp = 8'd60; m_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        tick();                 // accepted, now in COUNT
        a_valid = 1'b0;
        tick();                 // now in SHIFT
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        last_m = 1'b1;
        n_cmp++;
        if ({busy, out_valid, out_mant, out_exp, out_src, out_zero, out_uflow} !== 37'd0) begin
            n_err++;
            $display("FAIL midop_reset: busy=%b valid=%b mant=%h exp=%0d src=%b z=%b u=%b required all 0",
                     busy, out_valid, out_mant, out_exp, out_src, out_zero, out_uflow);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL midop_dropped: cycle %0d out_valid=%b busy=%b required 0 0", c, out_valid, busy);
            end
        end
        $display("txn reset in SHIFT dropped request");
    endtask

    task automatic test_random();
        logic [23:0] om, am, mm;
        logic [7:0]  oe, ae, me;
        logic        os, oz, ou;
        int          sel;
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(1, 3);
            am = 24'($urandom) >> $urandom_range(0, 24);
            mm = 24'($urandom) >> $urandom_range(0, 24);
            ae = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 255));
            me = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 255));
            do_txn(sel[0], sel[1], am, ae, mm, me, $urandom_range(0, 3), om, oe, os, oz, ou);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_valid = 1'b0; m_valid = 1'b0; out_ready = 1'b1;
        a_mant = 24'd0; m_mant = 24'd0; a_exp = 8'd0; m_exp = 8'd0;
        tick();
        test_reset();
        test_single_a();
        test_zero();
        test_underflow();
        test_backpressure();
        test_arbitration();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
